// File: rtl/entrada_buffer.sv
// -----------------------------------------------------------------------------
// entrada_buffer
//
// Parametrised input buffer for switch-driven data entry. Words on _input are
// pushed on switchRead and popped onto output_ on switchWrite. Storage behaves
// as a LIFO (MODE=0) or FIFO (MODE=1). It reports count/full/haveData status,
// a one-cycle out_valid strobe, and sticky overflow/underflow flags.
//
// Optional feature macro: ENTRADA_EDGE_DETECT_EN
//   When defined, the switches are registered and only a rising edge produces
//   a request. This gives one operation per press and 2-cycle press-to-output
//   latency. When undefined, requests are level-sensitive.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   _input       data word to store (DATA_IN_W)
//   switchRead   push request
//   switchWrite  pop request
//   err_clr      synchronous clear of overflow/underflow
//   output_      last popped word, extended to DATA_OUT_W, registered
//   out_valid    1-cycle pulse when output_ was updated
//   haveData     count != 0
//   full         count == DEPTH
//   count        number of entries held (CNT_W = $clog2(DEPTH+1))
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module entrada_buffer #(
  parameter int DATA_IN_W  = 16,
  parameter int DATA_OUT_W = 32,
  parameter int DEPTH      = 16,
  parameter int MODE       = 0,
  parameter int SIGN_EXT   = 0,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_IN_W-1:0]  _input,
  input  logic                  switchRead,
  input  logic                  switchWrite,
  input  logic                  err_clr,
  output logic [DATA_OUT_W-1:0] output_,
  output logic                  out_valid,
  output logic                  haveData,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, top, wr_idx;
  logic [DATA_IN_W-1:0]  head;
  logic [DATA_OUT_W-1:0] ext_head;
  logic                  push_req, pop_req;
  logic                  is_empty, is_full;
  logic                  do_push, do_pop, ovf_evt, unf_evt;

`ifdef ENTRADA_EDGE_DETECT_EN
  // A registered copy and its history give a one-cycle pulse per rising edge.
  // The armed flag stays low until the switch is seen low, so a switch that is
  // already held high when reset is released cannot fire.
  logic read_q, read_hist, read_armed;
  logic write_q, write_hist, write_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_q      <= 1'b0;
      read_hist   <= 1'b0;
      read_armed  <= 1'b0;
      write_q     <= 1'b0;
      write_hist  <= 1'b0;
      write_armed <= 1'b0;
    end else begin
      read_q      <= switchRead;
      read_hist   <= read_q;
      read_armed  <= read_armed | ~switchRead;
      write_q     <= switchWrite;
      write_hist  <= write_q;
      write_armed <= write_armed | ~switchWrite;
    end
  end

  assign push_req = read_q & ~read_hist & read_armed;
  assign pop_req  = write_q & ~write_hist & write_armed;
`else
  assign push_req = switchRead;
  assign pop_req  = switchWrite;
`endif

  // Wrap an index from DEPTH-1 back to 0; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign haveData = ~is_empty;
  assign full     = is_full;

  // A pop frees a slot in the same cycle, so a push is still accepted when full.
  assign do_pop  = pop_req & ~is_empty;
  assign do_push = push_req & (~is_full | do_pop);
  assign ovf_evt = push_req & ~pop_req & is_full;
  assign unf_evt = pop_req & is_empty;

  // In the LIFO, a simultaneous push and pop overwrites the current top.
  assign top    = PTR_W'(count - CNT_W'(1));
  assign wr_idx = (MODE != 0) ? wr_ptr : (do_pop ? top : PTR_W'(count));
  assign head   = (MODE != 0) ? mem[rd_ptr] : mem[top];

  always_comb begin
    ext_head = '0;
    if (SIGN_EXT != 0 && head[DATA_IN_W-1]) ext_head = '1;
    ext_head[DATA_IN_W-1:0] = head;
  end

  // The storage array has no reset; its contents are qualified by count.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_idx] <= _input;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      output_   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= do_pop;
      if (do_pop) output_ <= ext_head;

      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);

      if (MODE != 0) begin
        if (do_push) wr_ptr <= next_ptr(wr_ptr);
        if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      end

      // A new error event takes priority over err_clr in the same cycle.
      overflow  <= ovf_evt | (overflow & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_entrada_buffer.sv
// -----------------------------------------------------------------------------
// tb_entrada_buffer
//
// Drives two buffers side by side: a 4-deep zero-extending LIFO and a 3-deep
// sign-extending FIFO. A queue-based model predicts contents and flags; popped
// words are pushed to a scoreboard and matched against output_ on out_valid.
// -----------------------------------------------------------------------------
module tb_entrada_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [15:0] l_in = '0;
  logic        l_rd = 1'b0, l_wr = 1'b0, l_clr = 1'b0;
  logic [31:0] l_out;
  logic        l_valid, l_have, l_full, l_ovf, l_unf;
  logic [2:0]  l_count;

  logic [15:0] f_in = '0;
  logic        f_rd = 1'b0, f_wr = 1'b0, f_clr = 1'b0;
  logic [31:0] f_out;
  logic        f_valid, f_have, f_full, f_ovf, f_unf;
  logic [1:0]  f_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] l_mem[$], f_mem[$];
  logic [31:0] l_exp[$], f_exp[$];
  logic [31:0] l_last = '0, f_last = '0;
  bit          l_vld = 0, f_vld = 0;
  bit          l_ovf_m = 0, l_unf_m = 0, f_ovf_m = 0, f_unf_m = 0;

  always #5 clk = ~clk;

  entrada_buffer #(.DATA_IN_W(16), .DATA_OUT_W(32), .DEPTH(4), .MODE(0), .SIGN_EXT(0)) u_lifo (
    .clk(clk), .reset(reset), ._input(l_in), .switchRead(l_rd), .switchWrite(l_wr),
    .err_clr(l_clr), .output_(l_out), .out_valid(l_valid), .haveData(l_have),
    .full(l_full), .count(l_count), .overflow(l_ovf), .underflow(l_unf)
  );

  entrada_buffer #(.DATA_IN_W(16), .DATA_OUT_W(32), .DEPTH(3), .MODE(1), .SIGN_EXT(1)) u_fifo (
    .clk(clk), .reset(reset), ._input(f_in), .switchRead(f_rd), .switchWrite(f_wr),
    .err_clr(f_clr), .output_(f_out), .out_valid(f_valid), .haveData(f_have),
    .full(f_full), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("l_valid", 32'(l_valid), 32'(l_vld));
    if (l_valid === 1'b1) begin
      if (l_exp.size() == 0) checkOutput("l_unexpected_valid", 32'(l_valid), 32'd0);
      else begin
        l_last = l_exp.pop_front();
        checkOutput("l_out", l_out, l_last);
      end
    end else checkOutput("l_hold", l_out, l_last);
    checkOutput("l_count", 32'(l_count), 32'(l_mem.size()));
    checkOutput("l_full", 32'(l_full), 32'(l_mem.size() == 4));
    checkOutput("l_have", 32'(l_have), 32'(l_mem.size() != 0));
    checkOutput("l_ovf", 32'(l_ovf), 32'(l_ovf_m));
    checkOutput("l_unf", 32'(l_unf), 32'(l_unf_m));

    checkOutput("f_valid", 32'(f_valid), 32'(f_vld));
    if (f_valid === 1'b1) begin
      if (f_exp.size() == 0) checkOutput("f_unexpected_valid", 32'(f_valid), 32'd0);
      else begin
        f_last = f_exp.pop_front();
        checkOutput("f_out", f_out, f_last);
      end
    end else checkOutput("f_hold", f_out, f_last);
    checkOutput("f_count", 32'(f_count), 32'(f_mem.size()));
    checkOutput("f_full", 32'(f_full), 32'(f_mem.size() == 3));
    checkOutput("f_have", 32'(f_have), 32'(f_mem.size() != 0));
    checkOutput("f_ovf", 32'(f_ovf), 32'(f_ovf_m));
    checkOutput("f_unf", 32'(f_unf), 32'(f_unf_m));
  endtask

  // Drive one cycle of requests, advance the model, then check after the edge.
  task automatic applyStimulus(input logic [15:0] li, input bit lp, input bit lq, input bit lc,
                               input logic [15:0] fi, input bit fp, input bit fq, input bit fc);
    bit emp, ful, d_pop, d_push;
    logic [15:0] hd;
    l_in = li; l_rd = lp; l_wr = lq; l_clr = lc;
    f_in = fi; f_rd = fp; f_wr = fq; f_clr = fc;

    emp = (l_mem.size() == 0);
    ful = (l_mem.size() == 4);
    d_pop  = lq && !emp;
    d_push = lp && (!ful || d_pop);
    l_vld = d_pop;
    if (d_pop) begin
      hd = l_mem.pop_back();
      l_exp.push_back({16'h0000, hd});
    end
    if (d_push) l_mem.push_back(li);
    l_ovf_m = (lp && !lq && ful) || (l_ovf_m && !lc);
    l_unf_m = (lq && emp) || (l_unf_m && !lc);

    emp = (f_mem.size() == 0);
    ful = (f_mem.size() == 3);
    d_pop  = fq && !emp;
    d_push = fp && (!ful || d_pop);
    f_vld = d_pop;
    if (d_pop) begin
      hd = f_mem.pop_front();
      f_exp.push_back({{16{hd[15]}}, hd});
    end
    if (d_push) f_mem.push_back(fi);
    f_ovf_m = (fp && !fq && ful) || (f_ovf_m && !fc);
    f_unf_m = (fq && emp) || (f_unf_m && !fc);

    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic idleBoth();
    applyStimulus('0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkState();
    reset = 1'b1;

    // LIFO push 1..4; FIFO push A,B,C then D overflows.
    applyStimulus(16'h0001, 1, 0, 0, 16'h000A, 1, 0, 0);
    applyStimulus(16'h0002, 1, 0, 0, 16'h000B, 1, 0, 0);
    applyStimulus(16'h0003, 1, 0, 0, 16'h000C, 1, 0, 0);
    applyStimulus(16'h0004, 1, 0, 0, 16'h000D, 1, 0, 0);
    // Full LIFO push: dropped, overflow.
    applyStimulus(16'h0005, 1, 0, 0, 16'h0000, 0, 0, 0);
    // Pop x4: LIFO 4,3,2,1; FIFO A,B,C then underflow with output held.
    for (int i = 0; i < 4; i++) applyStimulus('0, 0, 1, 0, '0, 0, 1, 0);
    // Pop on empty LIFO, then clear both flags.
    applyStimulus('0, 0, 1, 0, '0, 0, 0, 0);
    applyStimulus('0, 0, 0, 1, '0, 0, 0, 1);

    // Extension: 0x8001 zero-extends in LIFO, sign-extends in FIFO.
    applyStimulus(16'h8001, 1, 0, 0, 16'h8001, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, '0, 0, 1, 0);
    idleBoth();

    // Push and pop together while empty: push lands, pop underflows.
    applyStimulus(16'h1111, 1, 1, 0, 16'h2222, 1, 1, 0);
    // Push and pop together while holding data: replace top / advance.
    applyStimulus(16'h3333, 1, 1, 1, 16'h4444, 1, 1, 1);
    applyStimulus('0, 0, 1, 0, '0, 0, 1, 0);

    // Fill FIFO, then 10 cycles of push+pop across pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus('0, 0, 0, 0, 16'(16'h0100 + i), 1, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(16'(16'h0200 + i), 1, (i > 0), 0, 16'(16'h0F00 + i), 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus('0, 0, 1, 0, '0, 0, 1, 1);

    // Random traffic on both buffers.
    for (int i = 0; i < 60; i++)
      applyStimulus(16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0),
                    16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));

    // Asynchronous reset in the middle of a push cycle.
    l_in = 16'hBEEF; l_rd = 1'b1; l_wr = 1'b0; l_clr = 1'b0;
    f_in = 16'hBEEF; f_rd = 1'b1; f_wr = 1'b0; f_clr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    l_mem.delete(); f_mem.delete();
    l_last = '0; f_last = '0;
    l_vld = 0; f_vld = 0;
    l_ovf_m = 0; l_unf_m = 0; f_ovf_m = 0; f_unf_m = 0;
    checkOutput("l_sb_drain", 32'(l_exp.size()), 32'd0);
    checkOutput("f_sb_drain", 32'(f_exp.size()), 32'd0);
    l_exp.delete(); f_exp.delete();
    checkState();
    l_rd = 1'b0; f_rd = 1'b0;
    @(posedge clk);
    #1;
    checkState();
    reset = 1'b1;
    applyStimulus(16'h0042, 1, 0, 0, 16'h0043, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, '0, 0, 1, 0);
    idleBoth();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
